bram_tdp_be_pipe: RTL and testbench

//  Single-clock true-dual-port byte-enable block RAM with per-port req/valid handshake and configurable read latency.

---
 rtl/bram_tdp_be_pipe_if.sv | 24 ++
 rtl/bram_tdp_be_pipe.sv | 126 ++++++++++++
 tb/tb_bram_tdp_be_pipe.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_tdp_be_pipe_if.sv
// bram_tdp_be_pipe_if: port A / port B request-response bundle for bram_tdp_be_pipe.
interface bram_tdp_be_pipe_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int ADDR_W    = 9
);
    localparam int DW = NB_COL * COL_WIDTH;
    logic              a_req, b_req;
    logic [NB_COL-1:0] a_we, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DW-1:0]     a_din, b_din;
    logic              a_ready, b_ready;
    logic              a_rvalid, b_rvalid;
    logic [DW-1:0]     a_dout, b_dout;
    logic              init_busy;
    modport master (
        output a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
        input  a_ready, a_rvalid, a_dout, b_ready, b_rvalid, b_dout, init_busy
    );
    modport slave (
        input  a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
        output a_ready, a_rvalid, a_dout, b_ready, b_rvalid, b_dout, init_busy
    );
endinterface

// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: true-dual-port byte-enable RAM with pipelined rvalid and optional clear sweep.
// Defining BRAM_TDP_COLLISION_DET_EN adds the coll_pulse / coll_cnt collision monitor.
module bram_tdp_be_pipe #(
    parameter int    NB_COL         = 4,
    parameter int    COL_WIDTH      = 8,
    parameter int    RAM_DEPTH      = 512,
    parameter int    RD_LATENCY     = 2,
    parameter string WRITE_MODE     = "READ_FIRST",
    parameter bit    CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_tdp_be_pipe_if.slave bus
`ifdef BRAM_TDP_COLLISION_DET_EN
    ,
    output logic              coll_pulse,
    output logic [15:0]       coll_cnt
`endif
);
    localparam int ADDR_W = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
    localparam int DW     = NB_COL * COL_WIDTH;
    localparam bit WF     = WRITE_MODE == "WRITE_FIRST";
    localparam bit NC     = WRITE_MODE == "NO_CHANGE";

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic              busy;
    logic [ADDR_W-1:0] clr_addr;
    logic [DW-1:0]     mem [RAM_DEPTH];
    logic [1:0]        req, acc, wr, inr, vin;
    logic              same;
    logic [NB_COL-1:0] we [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DW-1:0]     din [2], old [2], rdat [2];
    logic [RD_LATENCY-1:0] pv [2];
    logic [DW-1:0]     pd [2][RD_LATENCY];

    assign req     = {bus.b_req, bus.a_req};
    assign we[0]   = bus.a_we;
    assign we[1]   = bus.b_we;
    assign addr[0] = bus.a_addr;
    assign addr[1] = bus.b_addr;
    assign din[0]  = bus.a_din;
    assign din[1]  = bus.b_din;

    assign acc  = req & {2{!busy}};
    assign wr   = acc & {|we[1], |we[0]};
    assign inr  = {32'(addr[1]) < RAM_DEPTH, 32'(addr[0]) < RAM_DEPTH};
    assign same = &acc && addr[0] == addr[1];
    assign vin  = acc & ~(wr & {2{NC}});

    // Own-write view: lanes both ports write show A's data, matching what the array keeps.
    always_comb
        for (int p = 0; p < 2; p++) begin
            old[p] = inr[p] ? mem[addr[p]] : '0;
            rdat[p] = old[p];
            for (int i = 0; i < NB_COL; i++)
                if (WF && wr[p] && inr[p] && we[p][i])
                    rdat[p][i*COL_WIDTH +: COL_WIDTH] = same && wr[0] && we[0][i]
                        ? din[0][i*COL_WIDTH +: COL_WIDTH] : din[p][i*COL_WIDTH +: COL_WIDTH];
        end

    // B is written first so A's lane overrides it on a shared address.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_addr] <= '0;
        for (int i = 0; i < NB_COL; i++) begin
            if (wr[1] && inr[1] && we[1][i])
                mem[addr[1]][i*COL_WIDTH +: COL_WIDTH] <= din[1][i*COL_WIDTH +: COL_WIDTH];
            if (wr[0] && inr[0] && we[0][i])
                mem[addr[0]][i*COL_WIDTH +: COL_WIDTH] <= din[0][i*COL_WIDTH +: COL_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            busy     <= CLEAR_ON_RESET;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (32'(clr_addr) == RAM_DEPTH - 1) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end

    // Data stages load only behind a valid, so the last stage holds dout between pulses.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                pv[p] <= '0;
                for (int s = 0; s < RD_LATENCY; s++) pd[p][s] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv[p][0] <= vin[p];
                if (vin[p]) pd[p][0] <= rdat[p];
                for (int s = 1; s < RD_LATENCY; s++) begin
                    pv[p][s] <= pv[p][s-1];
                    if (pv[p][s-1]) pd[p][s] <= pd[p][s-1];
                end
            end
        end

    assign bus.init_busy = busy;
    assign bus.a_ready   = !busy;
    assign bus.b_ready   = !busy;
    assign bus.a_rvalid  = pv[0][RD_LATENCY-1];
    assign bus.b_rvalid  = pv[1][RD_LATENCY-1];
    assign bus.a_dout    = pd[0][RD_LATENCY-1];
    assign bus.b_dout    = pd[1][RD_LATENCY-1];

`ifdef BRAM_TDP_COLLISION_DET_EN
    logic coll;
    assign coll = same && |wr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            coll_pulse <= 1'b0;
            coll_cnt   <= '0;
        end else begin
            coll_pulse <= coll;
            if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: directed vectors for a 512-deep READ_FIRST (latency 2) and a 20-deep WRITE_FIRST (latency 1) instance.
module tb_bram_tdp_be_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_tdp_be_pipe_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(9)) bus ();
    bram_tdp_be_pipe_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(5)) bus2 ();

`ifdef BRAM_TDP_COLLISION_DET_EN
    logic        coll_pulse, coll_pulse2;
    logic [15:0] coll_cnt, coll_cnt2;
`endif

    bram_tdp_be_pipe #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(512), .RD_LATENCY(2),
        .WRITE_MODE("READ_FIRST"), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef BRAM_TDP_COLLISION_DET_EN
        , .coll_pulse(coll_pulse), .coll_cnt(coll_cnt)
`endif
    );

    bram_tdp_be_pipe #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(20), .RD_LATENCY(1),
        .WRITE_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef BRAM_TDP_COLLISION_DET_EN
        , .coll_pulse(coll_pulse2), .coll_cnt(coll_cnt2)
`endif
    );

    typedef struct {
        logic [3:0]  we;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_req = 0;  bus.b_req = 0;  bus.a_we = 0;  bus.b_we = 0;
        bus2.a_req = 0; bus2.b_req = 0; bus2.a_we = 0; bus2.b_we = 0;
    endtask

    task automatic set_a(input logic [3:0] we, input logic [8:0] addr, input logic [31:0] din);
        bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_din = din;
    endtask

    task automatic set_b(input logic [3:0] we, input logic [8:0] addr, input logic [31:0] din);
        bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_din = din;
    endtask

    task automatic op2(input logic [3:0] we, input logic [4:0] addr, input logic [31:0] din);
        bus2.a_req = 1; bus2.a_we = we; bus2.a_addr = addr; bus2.a_din = din;
        step();
        idle();
    endtask

    initial begin
        int n, bad_rdy, bad_rv;
        vecs[0]  = '{4'h0, 9'd5,   32'h0,        32'h0};
        vecs[1]  = '{4'h0, 9'd3,   32'h0,        32'h0};
        vecs[2]  = '{4'hF, 9'd5,   32'hA1B2C3D4, 32'h0};
        vecs[3]  = '{4'h0, 9'd5,   32'h0,        32'hA1B2C3D4};
        vecs[4]  = '{4'hF, 9'd7,   32'h11223344, 32'h0};
        vecs[5]  = '{4'h5, 9'd7,   32'hAABBCCDD, 32'h11223344};
        vecs[6]  = '{4'h0, 9'd7,   32'h0,        32'h11BB33DD};
        vecs[7]  = '{4'h0, 9'd511, 32'h0,        32'h0};
        vecs[8]  = '{4'h8, 9'd511, 32'hDEADBEEF, 32'h0};
        vecs[9]  = '{4'h0, 9'd511, 32'h0,        32'hDE000000};
        vecs[10] = '{4'hF, 9'd9,   32'hFFFFFFFF, 32'h0};
        vecs[11] = '{4'h0, 9'd9,   32'h0,        32'hFFFFFFFF};
        idle();
        bus.a_addr = 0; bus.b_addr = 0; bus.a_din = 0; bus.b_din = 0;
        bus2.a_addr = 0; bus2.b_addr = 0; bus2.a_din = 0; bus2.b_din = 0;
        step();
        step();
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_b_rvalid", bus.b_rvalid, 0);
        chk("rst_a_dout", bus.a_dout, 0);
        chk("rst_b_dout", bus.b_dout, 0);
        chk("rst_init_busy", bus.init_busy, 1);
        chk("rst_a_ready", bus.a_ready, 0);
        rst_n = 1;
        // Requests during the sweep must be ignored; the write to addr 3 is verified later.
        bad_rv = 0;
        set_a(4'hF, 9'd3, 32'hFFFFFFFF);
        set_b(4'h0, 9'd3, 32'h0);
        for (int k = 0; k < 100; k++) begin
            if (bus.a_rvalid || bus.b_rvalid) bad_rv++;
            step();
        end
        chk("sweep1_no_rvalid", bad_rv, 0);
        rst_n = 0;
        #1;
        chk("midrst_busy", bus.init_busy, 1);
        idle();
        step();
        rst_n = 1;
        n = 0; bad_rdy = 0; bad_rv = 0;
        while (bus.init_busy && n < 2000) begin
            if (bus.a_ready || bus.b_ready) bad_rdy++;
            if (bus.a_rvalid || bus.b_rvalid) bad_rv++;
            n++;
            step();
        end
        chk("sweep_cycles", n, 512);
        chk("sweep_ready_low", bad_rdy, 0);
        chk("sweep_no_rvalid", bad_rv, 0);
        chk("run_a_ready", bus.a_ready, 1);
        chk("run_b_ready", bus.b_ready, 1);

        for (int k = 0; k < 12; k++) begin
            set_a(vecs[k].we, vecs[k].addr, vecs[k].din);
            step();
            idle();
            chk($sformatf("vec%0d_early", k), bus.a_rvalid, 0);
            step();
            chk($sformatf("vec%0d_rvalid", k), bus.a_rvalid, 1);
            chk($sformatf("vec%0d_dout", k), bus.a_dout, vecs[k].exp);
            step();
            chk($sformatf("vec%0d_pulse", k), bus.a_rvalid, 0);
        end

        set_a(4'b0011, 9'd9, 32'h000000AA);
        set_b(4'b0110, 9'd9, 32'h0000BB00);
        step();
        idle();
`ifdef BRAM_TDP_COLLISION_DET_EN
        chk("coll_pulse", coll_pulse, 1);
        chk("coll_cnt1", coll_cnt, 1);
`endif
        step();
        chk("coll1_a_rvalid", bus.a_rvalid, 1);
        chk("coll1_b_rvalid", bus.b_rvalid, 1);
        chk("coll1_a_dout", bus.a_dout, 32'hFFFFFFFF);
        chk("coll1_b_dout", bus.b_dout, 32'hFFFFFFFF);
        set_a(4'h0, 9'd10, 32'h0);
        set_b(4'hF, 9'd10, 32'h55667788);
        step();
        idle();
        step();
        chk("coll2_a_dout", bus.a_dout, 32'h0);
        chk("coll2_b_dout", bus.b_dout, 32'h0);
        set_a(4'h0, 9'd9, 32'h0);
        set_b(4'h0, 9'd9, 32'h0);
        step();
        idle();
        step();
        chk("rr_a_dout", bus.a_dout, 32'hFF0000AA);
        chk("rr_b_dout", bus.b_dout, 32'hFF0000AA);
`ifdef BRAM_TDP_COLLISION_DET_EN
        chk("coll_cnt2", coll_cnt, 2);
`endif
        set_a(4'h0, 9'd10, 32'h0);
        step();
        idle();
        step();
        chk("coll2_word", bus.a_dout, 32'h55667788);

        for (int i = 0; i < 64; i++) begin
            set_a(4'hF, 9'(100 + i), 32'h10000000 + i * 32'h0101);
            set_b(4'hF, 9'(200 + i), 32'h20000000 + i);
            step();
        end
        idle();
        step(); step(); step();
        for (int j = 0; j < 66; j++) begin
            if (j < 64) begin
                set_a(4'h0, 9'(200 + j), 32'h0);
                set_b(4'h0, 9'(100 + j), 32'h0);
            end else idle();
            step();
            chk($sformatf("burst%0d_a_rvalid", j), bus.a_rvalid, (j >= 1 && j <= 64) ? 1 : 0);
            chk($sformatf("burst%0d_b_rvalid", j), bus.b_rvalid, (j >= 1 && j <= 64) ? 1 : 0);
            if (j >= 1 && j <= 64) begin
                chk($sformatf("burst%0d_a_dout", j), bus.a_dout, 32'h20000000 + (j - 1));
                chk($sformatf("burst%0d_b_dout", j), bus.b_dout, 32'h10000000 + (j - 1) * 32'h0101);
            end
        end
        idle();
        step();

        chk("d2_busy", bus2.init_busy, 0);
        op2(4'b0011, 5'd3, 32'h12345678);
        chk("d2_wf_rvalid", bus2.a_rvalid, 1);
        chk("d2_wf_dout", bus2.a_dout, 32'h00005678);
        step();
        chk("d2_pulse", bus2.a_rvalid, 0);
        op2(4'h0, 5'd25, 32'h0);
        chk("d2_oor_rvalid", bus2.a_rvalid, 1);
        chk("d2_oor_dout", bus2.a_dout, 32'h0);
        op2(4'hF, 5'd25, 32'hFFFFFFFF);
        op2(4'h0, 5'd3, 32'h0);
        chk("d2_rd3", bus2.a_dout, 32'h00005678);
        op2(4'h0, 5'd5, 32'h0);
        chk("d2_rd5_nowrap", bus2.a_dout, 32'h0);
        op2(4'h0, 5'd19, 32'h0);
        chk("d2_rd19", bus2.a_dout, 32'h0);
        bus2.b_req = 1; bus2.b_we = 4'b0110; bus2.b_addr = 5'd4; bus2.b_din = 32'h11223344;
        op2(4'b1100, 5'd4, 32'hAABBCCDD);
        chk("d2_coll_a_dout", bus2.a_dout, 32'hAABB0000);
        chk("d2_coll_b_dout", bus2.b_dout, 32'h00BB3300);
`ifdef BRAM_TDP_COLLISION_DET_EN
        chk("d2_coll_cnt", coll_cnt2, 1);
`endif
        op2(4'h0, 5'd4, 32'h0);
        chk("d2_coll_word", bus2.a_dout, 32'hAABB3300);

        set_a(4'h0, 9'd5, 32'h0);
        step();
        idle();
        rst_n = 0;
        #1;
        chk("flight_rvalid0", bus.a_rvalid, 0);
        chk("flight_dout", bus.a_dout, 0);
        step();
        chk("flight_rvalid1", bus.a_rvalid, 0);
        step();
        chk("flight_rvalid2", bus.a_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
